// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencing for the 16-bit pipelined MIPS core.
// Owns the program counter and decides, each cycle, whether IF/ID loads a
// fetched instruction, loads a bubble, or holds. It also keeps saturating
// fetch and stall performance counters.
module fetch_ctrl #(
  parameter int PC_W     = 4,
  parameter int PC_INC   = 1,
  parameter int RESET_PC = 0,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             halt_req,
  input  logic             ld_use_hazard,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  input  logic             imem_ready,
  output logic [PC_W-1:0]  pc,
  output logic [PC_W-1:0]  pcadd4,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             running,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10
  } state_t;

  localparam logic [PC_W-1:0]  PC_INC_C   = PC_W'(PC_INC);
  localparam logic [PC_W-1:0]  RESET_PC_C = PC_W'(RESET_PC);
  localparam logic [CNT_W-1:0] CNT_MAX_C  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE_C  = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [PC_W-1:0]  pc_r;
  logic [PC_W-1:0]  pc_nxt_s;
  logic [PC_W-1:0]  pc_inc_s;
  logic [CNT_W-1:0] fetch_cnt_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic             fetch_inc_s;
  logic             stall_inc_s;
  logic             we_s;
  logic             flush_s;

  // Sequential increment wraps naturally modulo 2^PC_W.
  assign pc_inc_s = pc_r + PC_INC_C;

  // Next-state, next-pc and IF/ID control; redirect outranks every other RUN case.
  always_comb begin
    state_nxt_s = state_r;
    pc_nxt_s    = pc_r;
    we_s        = 1'b1;
    flush_s     = 1'b1;
    fetch_inc_s = 1'b0;
    stall_inc_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_RUN: begin
        if (redirect_valid) begin
          pc_nxt_s = redirect_pc;
        end else if (halt_req) begin
          state_nxt_s = ST_HALT;
        end else if (ld_use_hazard) begin
          we_s        = 1'b0;
          flush_s     = 1'b0;
          stall_inc_s = 1'b1;
        end else if (!imem_ready) begin
          stall_inc_s = 1'b1;
        end else begin
          pc_nxt_s    = pc_inc_s;
          flush_s     = 1'b0;
          fetch_inc_s = 1'b1;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and program counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC_C;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
    end
  end

  // Saturating performance counters: they stop at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_r <= '0;
      stall_cnt_r <= '0;
    end else begin
      if (fetch_inc_s && (fetch_cnt_r != CNT_MAX_C)) begin
        fetch_cnt_r <= fetch_cnt_r + CNT_ONE_C;
      end
      if (stall_inc_s && (stall_cnt_r != CNT_MAX_C)) begin
        stall_cnt_r <= stall_cnt_r + CNT_ONE_C;
      end
    end
  end

  assign pc         = pc_r;
  assign pcadd4     = pc_inc_s;
  assign ifid_we    = we_s;
  assign ifid_flush = flush_s;
  assign running    = (state_r == ST_RUN);
  assign halted     = (state_r == ST_HALT);
  assign fetch_cnt  = fetch_cnt_r;
  assign stall_cnt  = stall_cnt_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed scenario tests for fetch_ctrl. A second instance
// with 2-bit counters shares the stimulus to exercise counter saturation.
module tb_fetch_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        halt_req;
  logic        ld_use_hazard;
  logic        redirect_valid;
  logic [3:0]  redirect_pc;
  logic        imem_ready;
  logic [3:0]  pc;
  logic [3:0]  pcadd4;
  logic        ifid_we;
  logic        ifid_flush;
  logic        running;
  logic        halted;
  logic [15:0] fetch_cnt;
  logic [15:0] stall_cnt;
  logic [3:0]  pc2;
  logic [3:0]  pcadd4_2;
  logic        ifid_we2;
  logic        ifid_flush2;
  logic        running2;
  logic        halted2;
  logic [1:0]  fetch_cnt2;
  logic [1:0]  stall_cnt2;

  int tests;
  int fails;

  fetch_ctrl #(.PC_W(4), .PC_INC(1), .RESET_PC(0), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .ld_use_hazard(ld_use_hazard), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_ready(imem_ready),
    .pc(pc), .pcadd4(pcadd4), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
    .running(running), .halted(halted), .fetch_cnt(fetch_cnt), .stall_cnt(stall_cnt)
  );

  fetch_ctrl #(.PC_W(4), .PC_INC(1), .RESET_PC(0), .CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .ld_use_hazard(ld_use_hazard), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem_ready(imem_ready),
    .pc(pc2), .pcadd4(pcadd4_2), .ifid_we(ifid_we2), .ifid_flush(ifid_flush2),
    .running(running2), .halted(halted2), .fetch_cnt(fetch_cnt2), .stall_cnt(stall_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; halt_req = 1'b0; ld_use_hazard = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 4'd0; imem_ready = 1'b1;
  endtask

  // Spend one RUN cycle redirecting to a target, to position pc.
  task automatic go_to(input logic [3:0] target);
    redirect_valid = 1'b1; redirect_pc = target;
    tick();
    redirect_valid = 1'b0; redirect_pc = 4'd0;
  endtask

  task automatic test_reset();
    idle_inputs();
    imem_ready = 1'b0;
    rst_n = 1'b0;
    #12;
    tests++; if (pc !== 4'd0) begin fails++; $display("FAIL reset_pc: got %0d exp 0", pc); end
    tests++; if (running !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL reset_state: got run=%0b halt=%0b exp 0/0", running, halted); end
    tests++; if (fetch_cnt !== 16'd0 || stall_cnt !== 16'd0) begin fails++; $display("FAIL reset_cnt: got %0d/%0d exp 0/0", fetch_cnt, stall_cnt); end
    tests++; if (ifid_we !== 1'b1 || ifid_flush !== 1'b1) begin fails++; $display("FAIL reset_ifid: got we=%0b fl=%0b exp 1/1", ifid_we, ifid_flush); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    // IDLE ignores inputs other than start.
    imem_ready = 1'b1; halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tests++; if (running !== 1'b0 || pc !== 4'd0) begin fails++; $display("FAIL idle_hold: got run=%0b pc=%0d exp 0/0", running, pc); end
  endtask

  task automatic test_basic_fetch();
    start = 1'b1;
    #1;
    tests++; if (ifid_flush !== 1'b1 || ifid_we !== 1'b1) begin fails++; $display("FAIL idle_bubble: got we=%0b fl=%0b exp 1/1", ifid_we, ifid_flush); end
    tick();
    start = 1'b0;
    tests++; if (running !== 1'b1) begin fails++; $display("FAIL start_run: got %0b exp 1", running); end
    for (int i = 0; i < 5; i++) begin
      tests++; if (pc !== 4'(i) || pcadd4 !== 4'(i + 1)) begin fails++; $display("FAIL fetch_pc%0d: got pc=%0d pcadd4=%0d exp %0d/%0d", i, pc, pcadd4, i, i + 1); end
      tests++; if (ifid_flush !== 1'b0 || ifid_we !== 1'b1) begin fails++; $display("FAIL fetch_ifid%0d: got we=%0b fl=%0b exp 1/0", i, ifid_we, ifid_flush); end
      tick();
    end
    tests++; if (pc !== 4'd5) begin fails++; $display("FAIL fetch_pc_end: got %0d exp 5", pc); end
    tests++; if (fetch_cnt !== 16'd5) begin fails++; $display("FAIL fetch_cnt: got %0d exp 5", fetch_cnt); end
    tests++; if (fetch_cnt2 !== 2'd3) begin fails++; $display("FAIL fetch_cnt_sat: got %0d exp 3", fetch_cnt2); end
    tick();
    tests++; if (fetch_cnt2 !== 2'd3 || fetch_cnt !== 16'd6) begin fails++; $display("FAIL fetch_cnt_sat_hold: got %0d/%0d exp 3/6", fetch_cnt2, fetch_cnt); end
  endtask

  task automatic test_hazard();
    // pc is now 6
    ld_use_hazard = 1'b1;
    #1;
    tests++; if (ifid_we !== 1'b0) begin fails++; $display("FAIL hazard_we: got %0b exp 0", ifid_we); end
    tick();
    ld_use_hazard = 1'b0;
    tests++; if (pc !== 4'd6 || stall_cnt !== 16'd1) begin fails++; $display("FAIL hazard_hold: got pc=%0d stall=%0d exp 6/1", pc, stall_cnt); end
    tick();
    tests++; if (pc !== 4'd7 || fetch_cnt !== 16'd7) begin fails++; $display("FAIL hazard_resume: got pc=%0d fetch=%0d exp 7/7", pc, fetch_cnt); end
  endtask

  task automatic test_redirect_priority();
    go_to(4'd3);
    tests++; if (pc !== 4'd3) begin fails++; $display("FAIL redirect_3: got %0d exp 3", pc); end
    redirect_valid = 1'b1; redirect_pc = 4'd12; ld_use_hazard = 1'b1; halt_req = 1'b1;
    #1;
    tests++; if (ifid_flush !== 1'b1 || ifid_we !== 1'b1) begin fails++; $display("FAIL redirect_ifid: got we=%0b fl=%0b exp 1/1", ifid_we, ifid_flush); end
    tick();
    redirect_valid = 1'b0; ld_use_hazard = 1'b0; halt_req = 1'b0;
    tests++; if (pc !== 4'd12 || running !== 1'b1) begin fails++; $display("FAIL redirect_pc: got pc=%0d run=%0b exp 12/1", pc, running); end
    tests++; if (fetch_cnt !== 16'd7 || stall_cnt !== 16'd1) begin fails++; $display("FAIL redirect_cnt: got %0d/%0d exp 7/1", fetch_cnt, stall_cnt); end
  endtask

  task automatic test_imem_wait();
    go_to(4'd9);
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++; if (pc !== 4'd9 || ifid_flush !== 1'b1 || ifid_we !== 1'b1) begin fails++; $display("FAIL wait_bubble%0d: got pc=%0d we=%0b fl=%0b exp 9/1/1", i, pc, ifid_we, ifid_flush); end
      tick();
    end
    imem_ready = 1'b1;
    tests++; if (pc !== 4'd9 || stall_cnt !== 16'd4) begin fails++; $display("FAIL wait_stall: got pc=%0d stall=%0d exp 9/4", pc, stall_cnt); end
    tick();
    tests++; if (pc !== 4'd10 || fetch_cnt !== 16'd8) begin fails++; $display("FAIL wait_resume: got pc=%0d fetch=%0d exp 10/8", pc, fetch_cnt); end
  endtask

  task automatic test_halt();
    go_to(4'd5);
    halt_req = 1'b1;
    #1;
    tests++; if (ifid_flush !== 1'b1) begin fails++; $display("FAIL halt_flush: got %0b exp 1", ifid_flush); end
    tick();
    halt_req = 1'b0;
    tests++; if (halted !== 1'b1 || running !== 1'b0 || pc !== 4'd5) begin fails++; $display("FAIL halt_enter: got halt=%0b run=%0b pc=%0d exp 1/0/5", halted, running, pc); end
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++; if (pc !== 4'd5 || ifid_flush !== 1'b1 || ifid_we !== 1'b1) begin fails++; $display("FAIL halt_hold%0d: got pc=%0d we=%0b fl=%0b exp 5/1/1", i, pc, ifid_we, ifid_flush); end
    end
    tests++; if (fetch_cnt !== 16'd8 || stall_cnt !== 16'd4) begin fails++; $display("FAIL halt_cnt: got %0d/%0d exp 8/4", fetch_cnt, stall_cnt); end
    start = 1'b1;
    tick();
    start = 1'b0;
    tests++; if (running !== 1'b1 || pc !== 4'd5) begin fails++; $display("FAIL halt_resume: got run=%0b pc=%0d exp 1/5", running, pc); end
    tick();
    tests++; if (pc !== 4'd6 || fetch_cnt !== 16'd9) begin fails++; $display("FAIL halt_fetch: got pc=%0d fetch=%0d exp 6/9", pc, fetch_cnt); end
  endtask

  task automatic test_wrap();
    go_to(4'd15);
    tests++; if (pc !== 4'd15 || pcadd4 !== 4'd0) begin fails++; $display("FAIL wrap_pcadd4: got pc=%0d pcadd4=%0d exp 15/0", pc, pcadd4); end
    tick();
    tests++; if (pc !== 4'd0 || pcadd4 !== 4'd1) begin fails++; $display("FAIL wrap_pc: got pc=%0d pcadd4=%0d exp 0/1", pc, pcadd4); end
  endtask

  task automatic test_async_reset();
    go_to(4'd11);
    tests++; if (pc !== 4'd11 || fetch_cnt !== 16'd10 || stall_cnt !== 16'd4) begin fails++; $display("FAIL areset_pre: got pc=%0d f=%0d s=%0d exp 11/10/4", pc, fetch_cnt, stall_cnt); end
    #2;
    rst_n = 1'b0;
    #1;
    tests++; if (pc !== 4'd0 || running !== 1'b0 || halted !== 1'b0) begin fails++; $display("FAIL areset_state: got pc=%0d run=%0b halt=%0b exp 0/0/0", pc, running, halted); end
    tests++; if (fetch_cnt !== 16'd0 || stall_cnt !== 16'd0) begin fails++; $display("FAIL areset_cnt: got %0d/%0d exp 0/0", fetch_cnt, stall_cnt); end
    tests++; if (ifid_flush !== 1'b1 || ifid_we !== 1'b1) begin fails++; $display("FAIL areset_ifid: got we=%0b fl=%0b exp 1/1", ifid_we, ifid_flush); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b1;
    idle_inputs();
    #2;
    test_reset();
    test_basic_fetch();
    test_hazard();
    test_redirect_priority();
    test_imem_wait();
    test_halt();
    test_wrap();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
